// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache: refill FSM encoding,
// default geometry and helpers that derive the address-field widths.
package instruction_cache_pkg;

  localparam int ADDR_W    = 16;
  localparam int INSN_W    = 16;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_COMMIT = 2'd2
  } icache_state_e;

  // Word-offset field width for a line of the given size.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Line-index field width for the given number of lines.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag field width: whatever is left of the address above index and offset.
  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill controller: owns the IDLE/REFILL/COMMIT FSM, the word counter,
// the captured miss line address, the memory handshake and the deferred
// flush. The arrays themselves live in the parent.
module icache_refill_ctrl
  import instruction_cache_pkg::*;
#(
  parameter int WORDS = DEF_WORDS
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              miss_i,
  input  logic                              flush_i,
  input  logic [ADDR_W-off_w(WORDS)-1:0]    line_addr_i,
  input  logic                              mem_ack_i,
  output logic                              idle_o,
  output logic                              start_o,
  output logic                              fill_we_o,
  output logic [off_w(WORDS)-1:0]           word_o,
  output logic                              commit_o,
  output logic                              clear_all_o,
  output logic [ADDR_W-off_w(WORDS)-1:0]    line_addr_o,
  output logic                              mem_req_o,
  output logic [ADDR_W-1:0]                 mem_addr_o
);

  localparam int OFF_W  = off_w(WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  icache_state_e     state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              pend_q, pend_d;

  // State, counter, captured line and pending flush; reset abandons any transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and handshake outputs; acks outside REFILL are ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    pend_d      = pend_q;
    start_o     = 1'b0;
    fill_we_o   = 1'b0;
    commit_o    = 1'b0;
    clear_all_o = 1'b0;
    mem_req_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (flush_i) begin
          // A flush wins over a same-cycle miss; the miss is retried next cycle.
          clear_all_o = 1'b1;
        end else if (miss_i) begin
          state_d = ST_REFILL;
          line_d  = line_addr_i;
          cnt_d   = '0;
          start_o = 1'b1;
        end
      end
      ST_REFILL: begin
        mem_req_o = 1'b1;
        if (flush_i) pend_d = 1'b1;
        if (mem_ack_i) begin
          fill_we_o = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        commit_o = 1'b1;
        state_d  = ST_IDLE;
        // A flush seen during the refill wipes everything, including this line.
        if (pend_q || flush_i) clear_all_o = 1'b1;
        pend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign word_o      = cnt_q;
  assign line_addr_o = line_q;
  assign mem_addr_o  = (state_q == ST_REFILL) ? {line_q, cnt_q} : '0;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with combinational lookup. A miss in
// IDLE triggers an in-order, word-by-word line refill from memory.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic              inp_clk,
  input  logic              inp_rst_n,
  input  logic [ADDR_W-1:0] inp_address,
  output logic              out_hit,
  output logic [INSN_W-1:0] out_instruction,
  input  logic              inp_flush,
  output logic              out_mem_req,
  output logic [ADDR_W-1:0] out_mem_addr,
  input  logic              inp_mem_ack,
  input  logic [INSN_W-1:0] inp_mem_data
);

  localparam int OFF_W  = off_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES, WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INSN_W-1:0] data_q [LINES][WORDS];
  logic [LINES-1:0]  valid_q, valid_d;

  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              match;

  logic              idle, start, fill_we, commit, clear_all;
  logic [OFF_W-1:0]  fill_word;
  logic [LINE_W-1:0] ref_line;
  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;

  assign addr_off = inp_address[OFF_W-1:0];
  assign addr_idx = inp_address[OFF_W +: IDX_W];
  assign addr_tag = inp_address[ADDR_W-1 -: TAG_W];
  assign ref_idx  = ref_line[IDX_W-1:0];
  assign ref_tag  = ref_line[LINE_W-1 -: TAG_W];

  assign match           = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign out_hit         = idle && match;
  assign out_instruction = out_hit ? data_q[addr_idx][addr_off] : '0;

  icache_refill_ctrl #(
    .WORDS (WORDS)
  ) u_refill_ctrl (
    .clk_i       (inp_clk),
    .rst_ni      (inp_rst_n),
    .miss_i      (!match),
    .flush_i     (inp_flush),
    .line_addr_i (inp_address[ADDR_W-1:OFF_W]),
    .mem_ack_i   (inp_mem_ack),
    .idle_o      (idle),
    .start_o     (start),
    .fill_we_o   (fill_we),
    .word_o      (fill_word),
    .commit_o    (commit),
    .clear_all_o (clear_all),
    .line_addr_o (ref_line),
    .mem_req_o   (out_mem_req),
    .mem_addr_o  (out_mem_addr)
  );

  // Valid-bit update: the victim line is invalid for the whole refill; flush has priority.
  always_comb begin
    valid_d = valid_q;
    if (clear_all) begin
      valid_d = '0;
    end else begin
      if (start)  valid_d[addr_idx] = 1'b0;
      if (commit) valid_d[ref_idx]  = 1'b1;
    end
  end

  // Valid bits are the only array state that needs a reset.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) valid_q <= '0;
    else            valid_q <= valid_d;
  end

  // Tag and data storage, written by the refill path only.
  always_ff @(posedge inp_clk) begin
    if (fill_we) data_q[ref_idx][fill_word] <= inp_mem_data;
    if (commit)  tag_q[ref_idx] <= ref_tag;
  end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic        hit;
  logic [15:0] instr;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_cache #(.LINES(16), .WORDS(4)) dut (
    .inp_clk         (clk),
    .inp_rst_n       (rst_n),
    .inp_address     (address),
    .out_hit         (hit),
    .out_instruction (instr),
    .inp_flush       (flush),
    .out_mem_req     (mem_req),
    .out_mem_addr    (mem_addr),
    .inp_mem_ack     (mem_ack),
    .inp_mem_data    (mem_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one refill word after `delay` idle cycles; request must hold steady throughout.
  task automatic mem_word(input string tag, input logic [15:0] a, input logic [15:0] d, input int delay);
    for (int i = 0; i < delay; i++) begin
      mem_ack = 1'b0;
      #1;
      chk({tag, "_wait_req"}, {15'd0, mem_req}, 16'd1);
      chk({tag, "_wait_addr"}, mem_addr, a);
      tick();
    end
    mem_ack  = 1'b1;
    mem_data = d;
    #1;
    chk({tag, "_req"}, {15'd0, mem_req}, 16'd1);
    chk({tag, "_addr"}, mem_addr, a);
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'hxxxx;
  endtask

  initial begin
    rst_n    = 1'b0;
    address  = 16'h0000;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;

    // Reset state
    #2;
    chk("rst_hit", {15'd0, hit}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    tick();
    rst_n = 1'b1;

    // Cold miss on 0x0040 and refill A000..A003
    address = 16'h0040;
    #1;
    chk("cold_miss_hit", {15'd0, hit}, 16'd0);
    tick();
    for (int w = 0; w < 4; w++) mem_word("fillA", 16'h0040 + 16'(w), 16'hA000 + 16'(w), 0);
    #1;
    chk("commitA_req", {15'd0, mem_req}, 16'd0);
    chk("commitA_hit", {15'd0, hit}, 16'd0);
    tick();
    #1;
    chk("A_hit", {15'd0, hit}, 16'd1);
    chk("A_instr", instr, 16'hA000);

    // Same line, other word: zero-cycle hit, no request
    address = 16'h0042;
    #1;
    chk("A2_hit", {15'd0, hit}, 16'd1);
    chk("A2_instr", instr, 16'hA002);
    chk("A2_req", {15'd0, mem_req}, 16'd0);

    // Stray ack while idle must be ignored
    mem_ack  = 1'b1;
    mem_data = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("stray_req", {15'd0, mem_req}, 16'd0);
    chk("stray_instr", instr, 16'hA002);

    // Conflict: 0x0080 maps to index 0 with tag 2
    address = 16'h0080;
    #1;
    chk("conf_miss", {15'd0, hit}, 16'd0);
    tick();
    address = 16'h0123;  // address moves mid-refill; captured line must be kept
    mem_word("fillB0", 16'h0080, 16'hB000, 0);
    #1;
    chk("B_midrefill_hit", {15'd0, hit}, 16'd0);
    for (int w = 1; w < 4; w++) mem_word("fillB", 16'h0080 + 16'(w), 16'hB000 + 16'(w), 0);
    address = 16'h0080;
    #1;
    chk("commitB_hit", {15'd0, hit}, 16'd0);
    tick();
    #1;
    chk("B_hit", {15'd0, hit}, 16'd1);
    chk("B_instr", instr, 16'hB000);
    address = 16'h0040;
    #1;
    chk("A_evicted", {15'd0, hit}, 16'd0);
    tick();

    // Refetch 0x0040 with 3-cycle ack delay per word
    for (int w = 0; w < 4; w++) mem_word("fillC", 16'h0040 + 16'(w), 16'hC000 + 16'(w), 3);
    #1;
    chk("commitC_req", {15'd0, mem_req}, 16'd0);
    tick();
    #1;
    chk("C0_instr", instr, 16'hC000);
    address = 16'h0041;
    #1;
    chk("C1_instr", instr, 16'hC001);
    address = 16'h0043;
    #1;
    chk("C3_instr", instr, 16'hC003);

    // Flush pulsed during the second refill word
    address = 16'h0080;
    #1;
    tick();
    mem_word("fillD0", 16'h0080, 16'hD000, 0);
    flush = 1'b1;
    #1;
    chk("flushD_req", {15'd0, mem_req}, 16'd1);
    chk("flushD_addr", mem_addr, 16'h0081);
    tick();
    flush = 1'b0;
    for (int w = 1; w < 4; w++) mem_word("fillD", 16'h0080 + 16'(w), 16'hD000 + 16'(w), 0);
    #1;
    chk("commitD_hit", {15'd0, hit}, 16'd0);
    tick();
    #1;
    chk("D_flushed_hit", {15'd0, hit}, 16'd0);
    address = 16'h0040;
    #1;
    chk("A_after_flush_hit", {15'd0, hit}, 16'd0);
    tick();

    // Refetch of 0x0040 interrupted by reset after two acks
    mem_word("fillE0", 16'h0040, 16'hE000, 0);
    mem_word("fillE1", 16'h0041, 16'hE001, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", {15'd0, mem_req}, 16'd0);
    chk("rstmid_addr", mem_addr, 16'h0000);
    chk("rstmid_hit", {15'd0, hit}, 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_miss", {15'd0, hit}, 16'd0);
    tick();
    for (int w = 0; w < 4; w++) mem_word("fillF", 16'h0040 + 16'(w), 16'hF000 + 16'(w), 0);
    tick();
    #1;
    chk("F0_instr", instr, 16'hF000);
    address = 16'h0043;
    #1;
    chk("F3_instr", instr, 16'hF003);

    // Flush in IDLE with a same-cycle miss: lines cleared, no refill started
    address = 16'h0080;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("idle_flush_req", {15'd0, mem_req}, 16'd0);
    address = 16'h0040;
    #1;
    chk("idle_flush_hit", {15'd0, hit}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL expose parameters: LINES, default 16, number of direct-mapped lines; WORDS, default 4, 16-bit words per line.
REQ-002 SHALL have ports: inp_clk  in  1  single clock, all state updates on posedge.
REQ-003 SHALL have: inp_rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have: inp_address  in  16  word address from the PC stage.
REQ-005 SHALL have: out_hit  out  1  valid instruction for inp_address this cycle; drives the PC stage's inp_hit.
REQ-006 SHALL have: out_instruction  out  16  instruction word; 16'h0000 when out_hit=0.
REQ-007 SHALL have: inp_flush  in  1  invalidate-all request, one-cycle pulse.
REQ-008 SHALL have: out_mem_req  out  1  and out_mem_addr  out  16  refill word request to memory.
REQ-009 SHALL have: inp_mem_ack  in  1  and inp_mem_data  in  16  memory returns one word per ack.

Function
REQ-010 Address split (defaults): offset=[1:0], index=[5:2], tag=[15:6]; widths SHALL derive from LINES/WORDS via clog2.
REQ-011 Lookup SHALL be combinational: out_hit = (state==IDLE) && valid[index] && tag[index]==addr tag; zero-cycle latency.
REQ-012 FSM states: IDLE, REFILL, COMMIT.
REQ-013 IDLE -> REFILL on posedge when lookup misses and no flush is pending; miss address captured; word counter = 0.
REQ-014 REFILL: out_mem_req=1, out_mem_addr = {miss tag, miss index, counter}; line base is word 0, words fetched in order 0..WORDS-1.
REQ-015 Handshake: req and addr SHALL stay stable until inp_mem_ack is sampled high; on ack, inp_mem_data written to data[index][counter] and counter increments; next request issued the following cycle (req stays high, addr advances).
REQ-016 Ack on last word (counter==WORDS-1) -> COMMIT; out_mem_req=0 in COMMIT.
REQ-017 COMMIT: tag[index] and valid[index] written; -> IDLE next posedge; lookup re-evaluated against current inp_address.
REQ-018 inp_mem_ack while out_mem_req=0 SHALL be ignored.
REQ-019 out_hit SHALL be 0 in REFILL and COMMIT regardless of array contents.
REQ-020 inp_address changes during REFILL SHALL NOT alter the refill; captured miss address is used to completion.
REQ-021 Flush in IDLE: all valid bits clear on that posedge; same-cycle miss SHALL NOT start a refill that cycle.
REQ-022 Flush in REFILL/COMMIT: recorded as pending; refill completes; on entry to IDLE all valid bits clear (including the just-committed line), then pending clears.
REQ-023 A line replaced by refill SHALL have valid[index]=0 from REFILL entry until COMMIT.

Reset
REQ-024 On inp_rst_n=0, immediately: state=IDLE, all valid=0, counter=0, pending flush=0, out_mem_req=0, out_mem_addr=0; hence out_hit=0, out_instruction=0.
REQ-025 Reset mid-REFILL SHALL abandon the transfer; no partial line marked valid.
REQ-026 Tag/data arrays need not be reset.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, default LINES/WORDS, and address-field width constants.
REQ-028 One sub-module: icache_refill_ctrl (FSM, word counter, memory handshake, pending flush); arrays and lookup stay in instruction_cache.

Verification
REQ-029 Reset, address 16'h0040 -> out_hit=0, out_mem_req=1, out_mem_addr 16'h0040,41,42,43 with acks; data 16'hA000..A003 -> after COMMIT out_hit=1, out_instruction=16'hA000.
REQ-030 After REQ-029 fill, address 16'h0042 -> out_hit=1 same cycle, out_instruction=16'hA002, no memory request.
REQ-031 Conflict: address 16'h0080 (same index 0, tag 2) -> miss, refill, then 16'h0040 misses again.
REQ-032 Ack delayed 3 cycles per word -> req/addr held stable, 4 words total, no duplicate writes.
REQ-033 Flush pulsed during second refill word -> refill completes, line invalid in IDLE; 16'h0040 misses and refetches.
REQ-034 inp_rst_n low after 2 of 4 acks -> out_mem_req=0 at once; after release 16'h0040 misses and refetches from word 0.
